data_bus_bridge: RTL
====================

# data_bus_bridge

Adapter between the core's data port and the 32-bit word-organised data memory/peripheral bus. Converts byte/half/word load-store requests into word-aligned transfers with byte enables and lane steering. Returns load data right-justified, and generates the one-cycle-late `core_ready` the core's memory stage samples. Sits directly downstream of the core's data port; supports back-to-back accesses at one per cycle with a zero-wait memory.

## Interface
- `TIMEOUT`, default 255: maximum cycles waiting for `mem_ack` before aborting. A value of 0 disables the timeout.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `core_address`  in  32  byte address from the core.
- `core_width`  in  2  access width: 0 = byte, 1 = half, 2 = word. The value 3 is treated as word.
- `core_read`  in  1  load request.
- `core_write`  in  1  store request.
- `core_wdata`  in  32  store data, right-justified.
- `core_rdata`  out  32  load data, right-justified. Registered.
- `core_ready`  out  1  transfer completed. Registered; asserted in the cycle after completion.
- `mem_req`  out  1  bus request. Held until `mem_ack`.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  30  word address (byte address [31:2]).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-steered write data.
- `mem_rdata`  in  32  read word. Valid only in the `mem_ack` cycle.
- `mem_ack`  in  1  bus completes the current request this cycle.
- `bus_error`  out  1  sticky flag: timeout, or misalign when `DBUS_ALIGN_CHECK_EN` is defined. Cleared only by reset.

## Operation
- States: `IDLE`, `BUSY`.
- **IDLE**
  - `mem_*` is driven combinationally from the `core_*` inputs, so `mem_req = core_read | core_write`.
  - If both `core_read` and `core_write` are set, the write wins.
  - Request with `mem_ack` in the same cycle: the transfer completes. Stay in `IDLE`.
  - Request without `mem_ack`: capture address, width, we and wdata into holding registers, clear the wait counter, and go to `BUSY`.
- **BUSY**
  - `mem_*` is driven from the holding registers. Core inputs are ignored; the core repeats the same request anyway.
  - The wait counter increments every cycle.
  - `mem_ack`: the transfer completes, go to `IDLE`.
  - Counter reaches `TIMEOUT` (when `TIMEOUT` is non-zero): drop `mem_req`, complete with `core_rdata = 32'hDEAD_BEEF`, set `bus_error`, go to `IDLE`.
- **Completion (any state)**
  - The next cycle has `core_ready = 1`.
  - For reads, `core_rdata = mem_rdata >> (8*offset)`, registered. No sign/zero extension is done here; the core extends.
  - For writes, `core_rdata` holds its previous value.
  - In every cycle without a completion, `core_ready = 0`.
- **Lane rules** (`offset = address[1:0]`)
  - Byte: `be = 4'b0001 << offset`, `wdata = {4{wdata[7:0]}}`.
  - Half: `be = 4'b0011 << offset`, `wdata = {2{wdata[15:0]}}`.
  - Word: `be = 4'b1111`, `wdata` is passed through.
  - Reads drive the same `be` pattern.

## Timing
- Reset values: state `IDLE`, `core_ready` 0, `core_rdata` 0, `bus_error` 0, counter 0, holding registers 0.
- In `IDLE`, `mem_req`, `mem_be`, `mem_addr`, `mem_we` and `mem_wdata` follow the core inputs combinationally. The default with no request is `mem_req = 0`.
- Latency from request to `core_ready` is 1 + the number of wait cycles. A zero-wait memory gives `core_ready` in cycle N+1 for a request in cycle N.
- Back-to-back: a new request presented in the same cycle as `core_ready = 1` is accepted, because the block is already in `IDLE`.
- A timeout abort takes `TIMEOUT` + 1 cycles in `BUSY` before `core_ready`. A `mem_ack` arriving in the abort cycle takes priority over the timeout.
- Reset mid-transfer: `mem_req` drops immediately (asynchronous) and no `core_ready` is produced.

## Configuration
- `DBUS_ALIGN_CHECK_EN` **defined**:
  - A misaligned access (half with `offset = 3`, or word with `offset != 0`) is not forwarded, so `mem_req = 0`.
  - It completes next cycle with `core_ready = 1` and `core_rdata = 0`, and sets `bus_error`.
- `DBUS_ALIGN_CHECK_EN` **undefined**: no checking is done.
  - Half: offset bit 0 is ignored, so `offset = 3` behaves as 2.
  - Word: offset is forced to 0.
  - `bus_error` is set by timeout only.

## Test plan
- Zero-wait memory, `lw` at `0x100` with `mem_rdata = 0x11223344` -> `mem_addr = 0x40`, `be = 1111`; next cycle `core_ready = 1`, `core_rdata = 0x11223344`.
- `lb` at `0x103`, `mem_rdata = 0xAB000000` -> `be = 1000`, `core_rdata = 0x000000AB`. `sh` `0xBEEF` at `0x102` -> `be = 1100`, `mem_wdata = 0xBEEFBEEF`.
- Memory acks after 3 wait cycles on `sw` -> `mem_req` held 4 cycles with stable addr/data; `core_ready` pulses exactly once, on cycle 5.
- Back-to-back `lw`, `sw`, `lw` with a zero-wait memory -> three consecutive `core_ready` pulses with no bubbles and a correct `core_rdata` for each read.
- `TIMEOUT = 4`, memory never acks -> `mem_req` drops after 5 `BUSY` cycles, `core_ready = 1`, `core_rdata = 0xDEADBEEF`, `bus_error` sticks at 1.
- `lw` at `0x102` -> with the macro defined: `mem_req` stays 0, `core_ready` next cycle, `bus_error = 1`. Without it: `mem_addr = 0x40`, `be = 1111`. Reset asserted mid-`BUSY` -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/data_bus_bridge_if.sv
// Core-side and memory-side signal bundle for data_bus_bridge.
// master: the bridge's view. slave: the core/memory environment's view.
interface data_bus_bridge_if;
  logic [31:0] core_address;
  logic [1:0]  core_width;
  logic        core_read;
  logic        core_write;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_ready;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_error;

  modport master (
    input  core_address, core_width, core_read, core_write, core_wdata,
    input  mem_rdata, mem_ack,
    output core_rdata, core_ready, bus_error,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output core_address, core_width, core_read, core_write, core_wdata,
    output mem_rdata, mem_ack,
    input  core_rdata, core_ready, bus_error,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: converts byte/half/word core load-store requests into
// word-aligned bus transfers with byte enables and lane steering, returns
// right-justified load data and a registered one-cycle-late core_ready.
// Optional misalignment checking is enabled by defining DBUS_ALIGN_CHECK_EN.
module data_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  data_bus_bridge_if.master  bus
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_width;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_count;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_error;

  logic        w_busy;
  logic        w_core_req;
  logic [31:0] w_addr;
  logic [1:0]  w_width;
  logic        w_we;
  logic [31:0] w_wdata_in;
  logic [1:0]  w_off;
  logic        w_misalign;
  logic        w_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_shift;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_core_req = bus.core_read | bus.core_write;

  // Select the access source: live core inputs in IDLE, holding registers in BUSY
  always_comb begin
    w_addr     = bus.core_address;
    w_width    = bus.core_width;
    w_we       = bus.core_write;
    w_wdata_in = bus.core_wdata;
    if (w_busy) begin
      w_addr     = r_addr;
      w_width    = r_width;
      w_we       = r_we;
      w_wdata_in = r_wdata;
    end
  end

  // Effective lane offset and misalignment detection
  always_comb begin
    w_off      = w_addr[1:0];
    w_misalign = 1'b0;
    case (w_width)
      2'd0:    w_off = w_addr[1:0];
`ifdef DBUS_ALIGN_CHECK_EN
      2'd1: begin
        w_off      = w_addr[1:0];
        w_misalign = ~w_busy & w_core_req & (w_addr[1:0] == 2'd3);
      end
      default: begin
        w_off      = 2'd0;
        w_misalign = ~w_busy & w_core_req & (w_addr[1:0] != 2'd0);
      end
`else
      2'd1:    w_off = {w_addr[1], 1'b0};
      default: w_off = 2'd0;
`endif
    endcase
  end

  // Byte enables and write-data lane steering
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_wdata_in;
    case (w_width)
      2'd0: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{w_wdata_in[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{w_wdata_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = w_wdata_in;
      end
    endcase
  end

  assign w_req         = w_busy | (w_core_req & ~w_misalign);
  assign w_rdata_shift = bus.mem_rdata >> {w_off, 3'b000};

  // mem_req is gated by reset so it drops asynchronously even while the core
  // keeps presenting its request
  assign bus.mem_req    = w_req & ~reset;
  assign bus.mem_we     = w_we;
  assign bus.mem_addr   = w_addr[31:2];
  assign bus.mem_be     = w_be;
  assign bus.mem_wdata  = w_wdata;
  assign bus.core_ready = r_ready;
  assign bus.core_rdata = r_rdata;
  assign bus.bus_error  = r_error;

  // Transfer FSM: zero-wait completion in IDLE, wait/timeout handling in BUSY
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_width <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_misalign) begin
            r_ready <= 1'b1;
            r_rdata <= '0;
            r_error <= 1'b1;
          end else if (w_core_req) begin
            if (bus.mem_ack) begin
              r_ready <= 1'b1;
              if (!bus.core_write) r_rdata <= w_rdata_shift;
            end else begin
              r_addr  <= bus.core_address;
              r_width <= bus.core_width;
              r_we    <= bus.core_write;
              r_wdata <= bus.core_wdata;
              r_count <= '0;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_count <= r_count + 32'd1;
          if (bus.mem_ack) begin
            r_ready <= 1'b1;
            if (!r_we) r_rdata <= w_rdata_shift;
            r_state <= ST_IDLE;
          end else if ((TIMEOUT != 0) && (r_count == TIMEOUT)) begin
            r_ready <= 1'b1;
            r_rdata <= 32'hDEAD_BEEF;
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
